// File: rtl/fsm_pkg.sv
// Shared constants for the table-driven state machine: the standard default
// next-state and output tables, plus helpers that map them onto any table size.
package fsm_pkg;

  localparam int DEF_ROWS = 6;
  localparam int DEF_COLS = 4;

  // Rows are source states S0..S5, columns are input symbols 0..3.
  localparam int DEFAULT_NTAB [DEF_ROWS][DEF_COLS] = '{
    '{0, 1, 2, 3},
    '{0, 3, 1, 5},
    '{1, 3, 2, 4},
    '{1, 0, 4, 5},
    '{0, 1, 2, 5},
    '{1, 4, 0, 5}
  };

  // Bit i is output bit0 for state i.
  localparam logic [DEF_ROWS-1:0] DEFAULT_OTAB = 6'b010101;

  function automatic int default_next(int state, int sym, int num_states, int reset_state);
    int n;
    if (state < DEF_ROWS && sym < DEF_COLS) n = DEFAULT_NTAB[state][sym];
    else n = state;
    if (n >= num_states) n = reset_state;
    return n;
  endfunction

  function automatic int default_out(int state);
    if (state < DEF_ROWS) return DEFAULT_OTAB[state] ? 1 : 0;
    return 0;
  endfunction

endpackage

// File: rtl/fsm_cfg_table.sv
// Register-array lookup table: one write port, one asynchronous read port,
// and a synchronous reload of caller-supplied default contents.
module fsm_cfg_table #(
  parameter int AW = 3,
  parameter int DW = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [AW-1:0]              waddr,
  input  logic [DW-1:0]              wdata,
  input  logic [AW-1:0]              raddr,
  output logic [DW-1:0]              rdata,
  input  logic [(2**AW)-1:0][DW-1:0] init_data
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= init_data[i];
    end else if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Asynchronous read: a same-cycle write is only visible after the edge.
  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/table_fsm.sv
// Table-driven Moore state machine with run-time rewritable tables, input
// qualification, dwell counting, transition pulse and illegal-state recovery.
module table_fsm
  import fsm_pkg::*;
#(
  parameter int NUM_STATES  = 6,
  parameter int STATE_W     = $clog2(NUM_STATES),
  parameter int IN_W        = 2,
  parameter int OUT_W       = 1,
  parameter int RESET_STATE = 0,
  parameter int DWELL_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [IN_W-1:0]    input_signal,
  input  logic               cfg_we,
  input  logic [STATE_W-1:0] cfg_state,
  input  logic [IN_W-1:0]    cfg_sym,
  input  logic [STATE_W-1:0] cfg_next,
  input  logic               cfg_out_we,
  input  logic [OUT_W-1:0]   cfg_out,
  output logic               cfg_err,
  output logic [STATE_W-1:0] current_state,
  output logic [OUT_W-1:0]   output_signal,
  output logic               state_changed,
  output logic [DWELL_W-1:0] dwell_count
);

  localparam int NTAB_AW    = STATE_W + IN_W;
  localparam int NTAB_DEPTH = 2 ** NTAB_AW;
  localparam int OTAB_DEPTH = 2 ** STATE_W;
  localparam int NUM_SYMS   = 2 ** IN_W;

  // One extra bit so NUM_STATES itself is representable for the range checks.
  localparam logic [STATE_W:0]   NUM_STATES_W = (STATE_W + 1)'(NUM_STATES);
  localparam logic [STATE_W-1:0] RESET_S      = STATE_W'(RESET_STATE);

  logic [NTAB_DEPTH-1:0][STATE_W-1:0] ntab_init;
  logic [OTAB_DEPTH-1:0][OUT_W-1:0]   otab_init;

  genvar gi;
  generate
    for (gi = 0; gi < NTAB_DEPTH; gi++) begin : g_ntab_init
      assign ntab_init[gi] = STATE_W'(default_next(gi / NUM_SYMS, gi % NUM_SYMS,
                                                   NUM_STATES, RESET_STATE));
    end
    for (gi = 0; gi < OTAB_DEPTH; gi++) begin : g_otab_init
      assign otab_init[gi] = OUT_W'(default_out(gi));
    end
  endgenerate

  logic [STATE_W-1:0] state_reg, state_next;
  logic [DWELL_W-1:0] dwell_reg, dwell_next;
  logic               changed_reg, changed_next;
  logic               err_reg;
  logic               cfg_bad, ntab_we, otab_we, state_legal;
  logic [STATE_W-1:0] ntab_rdata;
  logic [OUT_W-1:0]   otab_rdata;

  // A rejected request blocks both table writes, not just the offending one.
  assign cfg_bad = (cfg_we || cfg_out_we) &&
                   (({1'b0, cfg_state} >= NUM_STATES_W) ||
                    (cfg_we && ({1'b0, cfg_next} >= NUM_STATES_W)));
  assign ntab_we = cfg_we && !cfg_bad;
  assign otab_we = cfg_out_we && !cfg_bad;

  fsm_cfg_table #(.AW(NTAB_AW), .DW(STATE_W)) u_ntab (
    .clk       (clk),
    .reset     (reset),
    .we        (ntab_we),
    .waddr     ({cfg_state, cfg_sym}),
    .wdata     (cfg_next),
    .raddr     ({state_reg, input_signal}),
    .rdata     (ntab_rdata),
    .init_data (ntab_init)
  );

  fsm_cfg_table #(.AW(STATE_W), .DW(OUT_W)) u_otab (
    .clk       (clk),
    .reset     (reset),
    .we        (otab_we),
    .waddr     (cfg_state),
    .wdata     (cfg_out),
    .raddr     (state_reg),
    .rdata     (otab_rdata),
    .init_data (otab_init)
  );

  assign state_legal = ({1'b0, state_reg} < NUM_STATES_W);

  always_comb begin
    state_next = state_reg;
    dwell_next = dwell_reg;
    if (!state_legal) begin
      state_next = RESET_S;
      dwell_next = '0;
    end else if (in_valid) begin
      state_next = ntab_rdata;
      if (ntab_rdata != state_reg) dwell_next = '0;
      else if (dwell_reg != '1)    dwell_next = dwell_reg + DWELL_W'(1);
    end
    changed_next = (state_next != state_reg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= RESET_S;
      dwell_reg   <= '0;
      changed_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dwell_reg   <= dwell_next;
      changed_reg <= changed_next;
      err_reg     <= cfg_bad;
    end
  end

  assign current_state = state_reg;
  assign output_signal = state_legal ? otab_rdata : '0;
  assign state_changed = changed_reg;
  assign dwell_count   = dwell_reg;
  assign cfg_err       = err_reg;

endmodule
